// File: rtl/pb_press_classifier_if.sv
// Bundles the debounced button pulses and the classified gesture strobes.
// No latency of its own; pure wiring between producer, classifier and consumer.
// No backpressure: all signals are single-cycle strobes or levels.
interface pb_press_classifier_if;
  logic press_pulse;
  logic release_pulse;
  logic short_press;
  logic double_press;
  logic long_press;
  logic repeat_pulse;
  logic busy;

  // Stimulus side: drives the debounced pulses, observes the gesture events
  modport master (
    output press_pulse,
    output release_pulse,
    input  short_press,
    input  double_press,
    input  long_press,
    input  repeat_pulse,
    input  busy
  );

  // Classifier side
  modport slave (
    input  press_pulse,
    input  release_pulse,
    output short_press,
    output double_press,
    output long_press,
    output repeat_pulse,
    output busy
  );
endinterface

// File: rtl/pb_press_classifier.sv
// Classifies debounced press/release pulses into short, double, long and auto-repeat events.
// Latency: each strobe is registered, high in the cycle after the edge that decides it.
// No backpressure: strobes are fire-and-forget; a press and release in the same cycle are dropped.
module pb_press_classifier #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int GAP_CYCLES    = 25_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  pb_press_classifier_if.slave  bus
);

  localparam int MAX_LG = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
  localparam int MAX_C  = (MAX_LG > REPEAT_CYCLES) ? MAX_LG : REPEAT_CYCLES;
  localparam int TW     = $clog2(MAX_C) + 1;

  localparam logic [TW-1:0] LONG_LAST   = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST    = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MAX   = {TW{1'b1}};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HELD1     = 3'd1,
    WAIT2     = 3'd2,
    HELD2     = 3'd3,
    LONG_HOLD = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          short_q, short_d;
  logic          double_q, double_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;
  logic          busy_q, busy_d;

  // A simultaneous press and release is a protocol violation: treat it as neither
  logic press_v, rel_v;
  assign press_v = bus.press_pulse && !bus.release_pulse;
  assign rel_v   = bus.release_pulse && !bus.press_pulse;

  // State, timer and output strobe registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      busy_q   <= busy_d;
    end
  end

  // Next state and timer: release/press beat the timeout on the same edge
  always_comb begin
    logic rep_wrap;
    state_d  = state_q;
    rep_wrap = 1'b0;
    case (state_q)
      IDLE:      if (press_v) state_d = HELD1;
      HELD1:     if (rel_v) state_d = WAIT2;
                 else if (timer_q == LONG_LAST) state_d = LONG_HOLD;
      WAIT2:     if (press_v) state_d = HELD2;
                 else if (timer_q == GAP_LAST) state_d = IDLE;
      HELD2:     if (rel_v) state_d = IDLE;
      LONG_HOLD: if (rel_v) state_d = IDLE;
                 else if (timer_q == REPEAT_LAST) rep_wrap = 1'b1;
      default:   state_d = IDLE;
    endcase
    // Timer restarts on every state change and on each repeat period; otherwise it saturates
    if ((state_d != state_q) || rep_wrap) timer_d = '0;
    else if (timer_q == TIMER_MAX)        timer_d = timer_q;
    else                                  timer_d = timer_q + 1'b1;
  end

  // Output strobes decoded from the transition taken this edge
  always_comb begin
    short_d  = (state_q == WAIT2)     && (state_d == IDLE);
    double_d = (state_q == HELD2)     && (state_d == IDLE);
    long_d   = (state_q == HELD1)     && (state_d == LONG_HOLD);
    repeat_d = (state_q == LONG_HOLD) && !rel_v && (timer_q == REPEAT_LAST);
    busy_d   = (state_d != IDLE);
  end

  assign bus.short_press  = short_q;
  assign bus.double_press = double_q;
  assign bus.long_press   = long_q;
  assign bus.repeat_pulse = repeat_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_pb_press_classifier.sv
// Bench for pb_press_classifier with small timing parameters.
// Directed gesture scenarios followed by random pulse traffic, all against a timestamp model.
// Inputs change on the falling edge; outputs are checked on the following falling edge.
module tb_pb_press_classifier;
  localparam int LONG   = 8;
  localparam int GAP    = 4;
  localparam int REPEAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pb_press_classifier_if bus ();

  pb_press_classifier #(
    .LONG_CYCLES   (LONG),
    .GAP_CYCLES    (GAP),
    .REPEAT_CYCLES (REPEAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int edge_n = 0;

  // Model: a gesture is described by how many presses it has seen and when things happened
  int g_presses = 0;
  bit g_held = 0;
  bit g_long = 0;
  int t_press, t_rel, t_long;
  bit exp_s, exp_d, exp_l, exp_r, exp_b;

  // Observed strobe counts for per-scenario totals
  int cnt_s, cnt_d, cnt_l, cnt_r;

  function automatic void gesture_clear();
    g_presses = 0;
    g_held    = 0;
    g_long    = 0;
  endfunction

  function automatic void model(bit p_in, bit r_in, bit rs, int n);
    bit p, r;
    p = p_in && !r_in;
    r = r_in && !p_in;
    exp_s = 0; exp_d = 0; exp_l = 0; exp_r = 0;
    if (rs) begin
      gesture_clear();
    end else if (g_presses == 0) begin
      if (p) begin g_presses = 1; g_held = 1; t_press = n; end
    end else if (g_presses == 1 && g_held && !g_long) begin
      if (r) begin g_held = 0; t_rel = n; end
      else if (n == t_press + LONG) begin exp_l = 1; g_long = 1; t_long = n; end
    end else if (g_presses == 1 && g_held) begin
      if (r) gesture_clear();
      else if ((n - t_long) % REPEAT == 0) exp_r = 1;
    end else if (g_presses == 1) begin
      if (p) begin g_presses = 2; g_held = 1; end
      else if (n == t_rel + GAP) begin exp_s = 1; gesture_clear(); end
    end else begin
      if (r) begin exp_d = 1; gesture_clear(); end
    end
    exp_b = (g_presses != 0);
  endfunction

  task automatic chk(string tag, logic obs, logic expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs, expv);
    end
  endtask

  task automatic chk_cnt(string tag, int obs, int expv);
    tests++;
    assert (obs == expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    chk("short_press",  bus.short_press,  exp_s);
    chk("double_press", bus.double_press, exp_d);
    chk("long_press",   bus.long_press,   exp_l);
    chk("repeat_pulse", bus.repeat_pulse, exp_r);
    chk("busy",         bus.busy,         exp_b);
    cnt_s += int'(bus.short_press === 1'b1);
    cnt_d += int'(bus.double_press === 1'b1);
    cnt_l += int'(bus.long_press === 1'b1);
    cnt_r += int'(bus.repeat_pulse === 1'b1);
  endtask

  // One clock edge: apply inputs on the falling edge, check the result one edge later
  task automatic step(bit p, bit r, bit rs);
    bus.press_pulse   = p;
    bus.release_pulse = r;
    rst               = rs;
    @(posedge clk);
    edge_n++;
    model(p, r, rs, edge_n);
    @(negedge clk);
    check_outputs();
  endtask

  function automatic bit has(int a[4], int n);
    for (int i = 0; i < 4; i++) if (a[i] == n) return 1'b1;
    return 1'b0;
  endfunction

  // Reset is taken on edge 0; scenario edges are numbered from 1 after it
  task automatic run_dir(string name, int len, int pe[4], int re[4], int rs_at,
                         int es, int ed, int el, int er);
    edge_n = -1;
    step(0, 0, 1);
    cnt_s = 0; cnt_d = 0; cnt_l = 0; cnt_r = 0;
    for (int n = 1; n <= len; n++) step(has(pe, n), has(re, n), n == rs_at);
    chk_cnt({name, " short count"},  cnt_s, es);
    chk_cnt({name, " double count"}, cnt_d, ed);
    chk_cnt({name, " long count"},   cnt_l, el);
    chk_cnt({name, " repeat count"}, cnt_r, er);
  endtask

  initial begin
    bus.press_pulse   = 1'b0;
    bus.release_pulse = 1'b0;
    @(negedge clk);

    run_dir("short",     25, '{10, -1, -1, -1}, '{13, -1, -1, -1}, -1, 1, 0, 0, 0);
    run_dir("double",    25, '{10, 14, -1, -1}, '{12, 16, -1, -1}, -1, 0, 1, 0, 0);
    run_dir("long",      35, '{10, -1, -1, -1}, '{28, -1, -1, -1}, -1, 0, 0, 1, 3);
    run_dir("racelong",  30, '{10, -1, -1, -1}, '{18, -1, -1, -1}, -1, 1, 0, 0, 0);
    run_dir("lastgap",   25, '{10, 16, -1, -1}, '{12, 17, -1, -1}, -1, 0, 1, 0, 0);
    run_dir("midreset",  35, '{10, 20, -1, -1}, '{15, 22, -1, -1}, 14, 1, 0, 0, 0);
    run_dir("collision", 20, '{5, -1, -1, -1},  '{5, -1, -1, -1},  -1, 0, 0, 0, 0);

    // Random pulse traffic with occasional resets; long holds arise from sparse pulses
    for (int i = 0; i < 4000; i++) begin
      int k;
      k = $urandom_range(0, 99);
      step(k < 9, (k >= 9 && k < 18) || k == 99, $urandom_range(0, 299) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
